// File: rtl/game_2048_pkg.sv
// game_2048_pkg
//   Shared types and defaults for the 2048 board datapath.
//   DEF_N / DEF_TW / DEF_SW : default board side, tile width, FSM state width
//   tile_t / board_t        : one tile, and a full DEF_N x DEF_N board
//   init_board()            : reset board of default size, one seed tile
package game_2048_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_TW       = 12;
   localparam int DEF_SW       = 3;
   localparam int DEF_INIT_ROW = DEF_N - 1;
   localparam int DEF_INIT_COL = 0;
   localparam int DEF_INIT_VAL = 2;

   typedef logic [DEF_TW-1:0] tile_t;
   typedef tile_t [DEF_N-1:0][DEF_N-1:0] board_t;

   function automatic board_t init_board();
      board_t b;
      b = '0;
      b[DEF_INIT_ROW][DEF_INIT_COL] = tile_t'(DEF_INIT_VAL);
      return b;
   endfunction

endpackage

// File: rtl/board_history.sv
// board_history
//   Bounded undo history: a LIFO kept in a ring of HDEPTH boards. When the
//   ring is full a push overwrites the oldest board, so the most recent
//   HDEPTH boards stay available.
//   clk, rst : clock, async active-high reset (clears pointer and count)
//   push     : store din at the write pointer
//   pop      : discard the most recent entry (dout shows it beforehand)
//   din      : board to store
//   dout     : most recent stored board (combinational read)
//   count    : number of boards available, saturates at HDEPTH
module board_history
   import game_2048_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int TW     = DEF_TW,
   parameter int HDEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic                            pop,
   input  logic [N-1:0][N-1:0][TW-1:0]     din,
   output logic [N-1:0][N-1:0][TW-1:0]     dout,
   output logic [$clog2(HDEPTH+1)-1:0]     count
);

   localparam int PW = (HDEPTH > 1) ? $clog2(HDEPTH) : 1;
   localparam int CW = $clog2(HDEPTH+1);

   typedef logic [N-1:0][N-1:0][TW-1:0] brd_t;

   brd_t          mem [HDEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(HDEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      return (p == '0) ? PW'(HDEPTH-1) : p - PW'(1);
   endfunction

   // The newest entry always sits just behind the write pointer.
   assign rd_ptr = ptr_dec(wr_ptr);
   assign dout   = mem[rd_ptr];

   // Storage carries no reset; count guards which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Push wins if both are asserted; the parent never issues both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= ptr_inc(wr_ptr);
         if (count != CW'(HDEPTH)) count <= count + CW'(1);
      end else if (pop && count != '0) begin
         wr_ptr <= rd_ptr;
         count  <= count - CW'(1);
      end
   end

endmodule

// File: rtl/board_state_reg.sv
// board_state_reg
//   Current-state register of the 2048 game: FSM state Q and board matrix_Q,
//   with load gating, committed-move counting and a bounded undo history.
//   clk, rst    : clock, async active-high reset (seeded board, counters 0)
//   D, matrix_D : next FSM state / next board, captured when load=1
//   load        : capture D and matrix_D this edge (beats undo)
//   commit      : load is a player move: push old board and count it,
//                 unless the board did not change
//   undo        : restore most recent history board (no effect if empty)
//   Q, matrix_Q : current state and board
//   changed     : one-cycle pulse, board altered by the last edge
//   moves       : committed move count, saturating, floored at 0 on undo
//   hist_count  : boards available for undo
//   undo_ok     : hist_count != 0 (combinational)
module board_state_reg
   import game_2048_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int TW       = DEF_TW,
   parameter int SW       = DEF_SW,
   parameter int HDEPTH   = 4,
   parameter int MCW      = 16,
   parameter int INIT_ROW = N - 1,
   parameter int INIT_COL = 0,
   parameter int INIT_VAL = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [SW-1:0]                   D,
   input  logic [N-1:0][N-1:0][TW-1:0]     matrix_D,
   input  logic                            load,
   input  logic                            commit,
   input  logic                            undo,
   output logic [SW-1:0]                   Q,
   output logic [N-1:0][N-1:0][TW-1:0]     matrix_Q,
   output logic                            changed,
   output logic [MCW-1:0]                  moves,
   output logic [$clog2(HDEPTH+1)-1:0]     hist_count,
   output logic                            undo_ok
);

   typedef logic [N-1:0][N-1:0][TW-1:0] brd_t;

   localparam logic [MCW-1:0] MOVES_MAX = {MCW{1'b1}};

   function automatic brd_t seed_board();
      brd_t b;
      b = '0;
      b[INIT_ROW][INIT_COL] = TW'(INIT_VAL);
      return b;
   endfunction

   localparam brd_t SEED = seed_board();

   logic differs;
   logic push;
   logic pop;
   brd_t hist_dout;

   // Whole-board compare; the FSM state plays no part in "did it move".
   assign differs = (matrix_D != matrix_Q);
   assign undo_ok = (hist_count != '0);
   assign push    = load & commit & differs;
   assign pop     = ~load & undo & undo_ok;

   board_history #(
      .N      (N),
      .TW     (TW),
      .HDEPTH (HDEPTH)
   ) u_history (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (matrix_Q),
      .dout  (hist_dout),
      .count (hist_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Q        <= '0;
         matrix_Q <= SEED;
         changed  <= 1'b0;
         moves    <= '0;
      end else begin
         changed <= 1'b0;
         if (load) begin
            Q        <= D;
            matrix_Q <= matrix_D;
            changed  <= differs;
            if (push && moves != MOVES_MAX) moves <= moves + MCW'(1);
         end else if (pop) begin
            matrix_Q <= hist_dout;
            changed  <= 1'b1;
            if (moves != '0) moves <= moves - MCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_board_state_reg.sv
// tb_board_state_reg
//   Table of {inputs, expected outputs} vectors plus hand-written sequences
//   for reset-in-flight, load/undo collision, and move-count saturation.
module tb_board_state_reg;
   import game_2048_pkg::*;

   localparam int MCW = 3;
   localparam int HW  = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [2:0]     D;
   board_t         matrix_D;
   logic           load, commit, undo;
   logic [2:0]     Q;
   board_t         matrix_Q;
   logic           changed;
   logic [MCW-1:0] moves;
   logic [HW-1:0]  hist_count;
   logic           undo_ok;

   board_state_reg #(
      .N(4), .TW(12), .SW(3), .HDEPTH(4), .MCW(MCW),
      .INIT_ROW(3), .INIT_COL(0), .INIT_VAL(2)
   ) dut (
      .clk(clk), .rst(rst), .D(D), .matrix_D(matrix_D),
      .load(load), .commit(commit), .undo(undo),
      .Q(Q), .matrix_Q(matrix_Q), .changed(changed), .moves(moves),
      .hist_count(hist_count), .undo_ok(undo_ok)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]     q;
      board_t         b;
      logic           ch;
      logic [MCW-1:0] m;
      logic [HW-1:0]  h;
   } exp_t;

   typedef struct {
      logic       ld, cm, un;
      logic [2:0] d;
      int         bi;
      exp_t       e;
   } vec_t;

   exp_t   exp_q[$];
   board_t brd[7];
   vec_t   vecs[14];
   int     n_tests = 0;
   int     n_fail  = 0;

   function automatic exp_t mk_exp(logic [2:0] q, board_t b, logic ch,
                                   logic [MCW-1:0] m, logic [HW-1:0] h);
      exp_t e;
      e.q = q; e.b = b; e.ch = ch; e.m = m; e.h = h;
      return e;
   endfunction

   task automatic check(string nm, logic [191:0] act, logic [191:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic compare_out(string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, " Q"},          192'(Q),          192'(e.q));
         check({tag, " matrix_Q"},   matrix_Q,         e.b);
         check({tag, " changed"},    192'(changed),    192'(e.ch));
         check({tag, " moves"},      192'(moves),      192'(e.m));
         check({tag, " hist_count"}, 192'(hist_count), 192'(e.h));
         check({tag, " undo_ok"},    192'(undo_ok),    192'(e.h != '0));
      end
   endtask

   task automatic drive(string tag, logic ld, logic cm, logic un,
                        logic [2:0] d, board_t b, exp_t e);
      @(negedge clk);
      load = ld; commit = cm; undo = un; D = d; matrix_D = b;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      compare_out(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      load = 1'b0; commit = 1'b0; undo = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      rst = 1'b1; load = 1'b0; commit = 1'b0; undo = 1'b0; D = '0;
      brd[0] = init_board();
      brd[1] = brd[0];
      brd[1][3][3] = 12'd2;
      for (int k = 2; k < 7; k++) begin
         brd[k] = brd[1];
         brd[k][0][0] = 12'(4 * k);
      end
      matrix_D = brd[0];

      //         ld cm un  D   board  Q  exp board ch m  h
      vecs[0]  = '{1, 1, 0, 1, 1, mk_exp(1, brd[1], 1, 1, 1)};
      vecs[1]  = '{0, 0, 0, 0, 0, mk_exp(1, brd[1], 0, 1, 1)};
      vecs[2]  = '{1, 1, 0, 2, 1, mk_exp(2, brd[1], 0, 1, 1)};
      vecs[3]  = '{1, 1, 0, 3, 2, mk_exp(3, brd[2], 1, 2, 2)};
      vecs[4]  = '{1, 1, 0, 4, 3, mk_exp(4, brd[3], 1, 3, 3)};
      vecs[5]  = '{1, 1, 0, 5, 4, mk_exp(5, brd[4], 1, 4, 4)};
      vecs[6]  = '{1, 1, 0, 6, 5, mk_exp(6, brd[5], 1, 5, 4)};
      vecs[7]  = '{0, 0, 1, 0, 0, mk_exp(6, brd[4], 1, 4, 3)};
      vecs[8]  = '{0, 0, 1, 0, 0, mk_exp(6, brd[3], 1, 3, 2)};
      vecs[9]  = '{0, 0, 1, 0, 0, mk_exp(6, brd[2], 1, 2, 1)};
      vecs[10] = '{0, 0, 1, 0, 0, mk_exp(6, brd[1], 1, 1, 0)};
      vecs[11] = '{0, 0, 1, 0, 0, mk_exp(6, brd[1], 0, 1, 0)};
      vecs[12] = '{1, 0, 0, 7, 6, mk_exp(7, brd[6], 1, 1, 0)};
      vecs[13] = '{0, 0, 1, 0, 0, mk_exp(7, brd[6], 0, 1, 0)};

      // Reset values while rst is held.
      @(negedge clk);
      exp_q.push_back(mk_exp(0, brd[0], 0, 0, 0));
      compare_out("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++)
         drive($sformatf("vec%0d", i), vecs[i].ld, vecs[i].cm, vecs[i].un,
               vecs[i].d, brd[vecs[i].bi], vecs[i].e);

      // Asynchronous reset between edges takes effect immediately.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      exp_q.push_back(mk_exp(0, brd[0], 0, 0, 0));
      compare_out("async_rst");
      #1 rst = 1'b0;

      // Load and undo on the same edge: load wins, undo does not pop.
      drive("lu_m1", 1, 1, 0, 1, brd[1], mk_exp(1, brd[1], 1, 1, 1));
      drive("lu_m2", 1, 1, 0, 2, brd[2], mk_exp(2, brd[2], 1, 2, 2));
      drive("lu_both", 1, 1, 1, 3, brd[3], mk_exp(3, brd[3], 1, 3, 3));
      drive("lu_m4", 1, 1, 0, 4, brd[4], mk_exp(4, brd[4], 1, 4, 4));

      // Reset pulsed between an undo request and its edge, history full.
      @(negedge clk);
      load = 1'b0; commit = 1'b0; undo = 1'b1;
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      exp_q.push_back(mk_exp(0, brd[0], 0, 0, 0));
      @(posedge clk);
      #1;
      compare_out("rst_undo");

      // Move counter saturates at its maximum, then undo decrements it.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         load = 1'b1; commit = 1'b1; undo = 1'b0; D = 3'd1;
         matrix_D = (i % 2 == 0) ? brd[1] : brd[2];
         @(posedge clk);
      end
      #1;
      exp_q.push_back(mk_exp(1, brd[1], 1, 7, 4));
      compare_out("sat");
      drive("sat_undo", 0, 0, 1, 0, brd[0], mk_exp(1, brd[2], 1, 6, 3));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
